// File: rtl/therm_bubble_correct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : therm_bubble_correct                                       |
// | Description : Synchronises a raw comparator word, captures it on each    |
// |               conversion strobe and removes single-bit bubbles with a    |
// |               3-input majority filter. Keeps a saturating bubble count   |
// |               and a sticky residual-error flag.                          |
// |               Optional macro THERM_FORCE_MONO_EN: apply a prefix-AND     |
// |               after the filter so thermo is always a legal code.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module therm_bubble_correct #(
    parameter int B           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sample,
    input  logic [(1<<B)-1:0]   comp,
    input  logic                clear_err,
    output logic [(1<<B)-1:0]   thermo,
    output logic                valid,
    output logic [15:0]         bubble_cnt,
    output logic                err_flag
);

    localparam int c_N = 1 << B;

    logic [SYNC_STAGES-1:0][c_N-1:0] r_sync;
    logic [c_N-1:0]                  r_cap;
    logic                            r_v1;
    logic [c_N-1:0]                  r_thermo;
    logic                            r_valid;
    logic [15:0]                     r_cnt;
    logic                            r_err;

    // Word extended with the boundary constants: below bit 0 reads as 1,
    // above bit N-1 reads as 0, so edge bits are filtered like interior bits.
    logic [c_N+1:0]                  w_ext;
    logic [c_N-1:0]                  w_maj;
    logic [c_N-1:0]                  w_out;
    logic                            w_resid;
    logic                            w_bubble;

    // Free-running comparator synchroniser, independent of the strobe
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= comp;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Stage 1: capture the synchronised word on a strobe
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cap <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= sample;
            if (sample) begin
                r_cap <= r_sync[SYNC_STAGES-1];
            end
        end
    end

    assign w_ext = {1'b0, r_cap, 1'b1};

    generate
        for (genvar i = 0; i < c_N; i++) begin : g_maj
            assign w_maj[i] = (w_ext[i] & w_ext[i+1]) |
                              (w_ext[i] & w_ext[i+2]) |
                              (w_ext[i+1] & w_ext[i+2]);
        end
    endgenerate

    // A 1 sitting directly above a 0, or a 0 at the bottom under any 1
    assign w_resid  = (|(w_maj[c_N-1:1] & ~w_maj[c_N-2:0])) |
                      (~w_maj[0] & (|w_maj));
    assign w_bubble = (w_maj != r_cap);

`ifdef THERM_FORCE_MONO_EN
    // Prefix-AND: each output bit is the AND of all filtered bits at or below it
    generate
        for (genvar i = 0; i < c_N; i++) begin : g_mono
            assign w_out[i] = &w_maj[i:0];
        end
    endgenerate
`else
    assign w_out = w_maj;
`endif

    // Stage 2: register the corrected word and the one-cycle valid pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_thermo <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= r_v1;
            if (r_v1) begin
                r_thermo <= w_out;
            end
        end
    end

    // Saturating count of captures that the filter had to change
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_v1 && w_bubble && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Sticky residual-error flag; a new error beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (r_v1 && w_resid) begin
            r_err <= 1'b1;
        end else if (clear_err) begin
            r_err <= 1'b0;
        end
    end

    assign thermo     = r_thermo;
    assign valid      = r_valid;
    assign bubble_cnt = r_cnt;
    assign err_flag   = r_err;

endmodule
`default_nettype wire
